// File: rtl/buscaminas_pkg.sv
// Shared types and helpers for the 8x8 minesweeper cell-reveal engine.
package buscaminas_pkg;

    localparam int N = 8;

    typedef enum logic [2:0] {
        ESPERA  = 3'd0,
        JUGANDO = 3'd1,
        EXPANDE = 3'd2,
        PERDIDO = 3'd3,
        GANADO  = 3'd4
    } estado_t;

    typedef logic [2:0] coord_t;
    typedef logic [2:0] conteo_t;

    // True when two coordinates differ by at most one; widened so row 7 + 1 cannot wrap to 0.
    function automatic logic cerca(input coord_t a, input coord_t b);
        logic [3:0] ea;
        logic [3:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea <= eb + 4'd1) && (eb <= ea + 4'd1);
    endfunction

endpackage

// File: rtl/revelar_casillas_if.sv
// Player request, board data and display status bundle of the cell-reveal engine.
interface revelar_casillas_if;
    import buscaminas_pkg::*;

    logic                       iniciar;
    coord_t                     sel_fila;
    coord_t                     sel_col;
    logic                       revelar;
    logic                       bandera;
    logic [3:0]                 num_minas;
    logic [7:0][7:0]            matriz;
    logic [0:7][0:7][2:0]       bombas_adyacentes;
    logic [7:0][7:0]            revelada;
    logic [7:0][7:0]            marcada;
    logic                       ocupado;
    logic                       perdio;
    logic                       gano;
    logic [6:0]                 reveladas;

    modport master (
        output iniciar, sel_fila, sel_col, revelar, bandera,
        output num_minas, matriz, bombas_adyacentes,
        input  revelada, marcada, ocupado, perdio, gano, reveladas
    );

    modport slave (
        input  iniciar, sel_fila, sel_col, revelar, bandera,
        input  num_minas, matriz, bombas_adyacentes,
        output revelada, marcada, ocupado, perdio, gano, reveladas
    );
endinterface

// File: rtl/vecino_cero.sv
// Flags whether cell (r, c) touches a revealed, mine-free, zero-count neighbour.
module vecino_cero
    import buscaminas_pkg::*;
(
    input  coord_t                r,
    input  coord_t                c,
    input  logic [7:0][7:0]       revelada,
    input  logic [7:0][7:0]       matriz,
    input  logic [0:7][0:7][2:0]  bombas_adyacentes,
    output logic                  hay_cero
);

    // Scan the whole board, keeping only the 8-connected in-bounds neighbours.
    always_comb begin
        hay_cero = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                hay_cero = hay_cero |
                    (cerca(coord_t'(i), r) && cerca(coord_t'(j), c) &&
                     !(coord_t'(i) == r && coord_t'(j) == c) &&
                     revelada[i][j] && !matriz[i][j] &&
                     (bombas_adyacentes[i][j] == 3'd0));
            end
        end
    end

endmodule

// File: rtl/revelar_casillas.sv
// Minesweeper cell-reveal engine: applies reveal/flag requests and flood-fills zero cells by raster sweeps.
module revelar_casillas
    import buscaminas_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    revelar_casillas_if.slave  bus
);

    estado_t         estado_r, estado_s;
    logic [7:0][7:0] revelada_r, revelada_s;
    logic [7:0][7:0] marcada_r, marcada_s;
    logic [6:0]      reveladas_r, reveladas_s;
    logic [6:0]      objetivo_s;
    logic [5:0]      k_r, k_s;
    logic            cambio_r, cambio_s;
    logic            revela_k_s;
    logic            vecino_s;
    logic            ocupado_r, perdio_r, gano_r;
    coord_t          f_s, c_s, kf_s, kc_s;

    assign f_s  = bus.sel_fila;
    assign c_s  = bus.sel_col;
    assign kf_s = k_r[5:3];
    assign kc_s = k_r[2:0];

    vecino_cero u_vecino_cero (
        .r                 (kf_s),
        .c                 (kc_s),
        .revelada          (revelada_r),
        .matriz            (bus.matriz),
        .bombas_adyacentes (bus.bombas_adyacentes),
        .hay_cero          (vecino_s)
    );

    // Next-state and datapath update for requests, win check and flood sweeps.
    always_comb begin
        estado_s    = estado_r;
        revelada_s  = revelada_r;
        marcada_s   = marcada_r;
        reveladas_s = reveladas_r;
        k_s         = k_r;
        cambio_s    = cambio_r;
        revela_k_s  = 1'b0;
        objetivo_s  = 7'd64 - {3'd0, bus.num_minas};
        if (bus.iniciar) begin
            estado_s    = JUGANDO;
            revelada_s  = '0;
            marcada_s   = '0;
            reveladas_s = 7'd0;
            k_s         = 6'd0;
            cambio_s    = 1'b0;
        end else begin
            case (estado_r)
                JUGANDO: begin
                    // A pending win swallows any request made in the same cycle.
                    if (reveladas_r == objetivo_s) begin
                        estado_s = GANADO;
                    end else if (bus.revelar) begin
                        if (revelada_r[f_s][c_s] || marcada_r[f_s][c_s]) begin
                            estado_s = JUGANDO;
                        end else if (bus.matriz[f_s][c_s]) begin
                            revelada_s = revelada_r | bus.matriz;
                            estado_s   = PERDIDO;
                        end else begin
                            revelada_s[f_s][c_s] = 1'b1;
                            reveladas_s          = reveladas_r + 7'd1;
                            if (bus.bombas_adyacentes[f_s][c_s] == 3'd0) begin
                                estado_s = EXPANDE;
                                k_s      = 6'd0;
                                cambio_s = 1'b0;
                            end else begin
                                estado_s = JUGANDO;
                            end
                        end
                    end else if (bus.bandera) begin
                        if (!revelada_r[f_s][c_s]) begin
                            marcada_s[f_s][c_s] = ~marcada_r[f_s][c_s];
                        end else begin
                            marcada_s = marcada_r;
                        end
                    end else begin
                        estado_s = JUGANDO;
                    end
                end
                EXPANDE: begin
                    revela_k_s = !revelada_r[kf_s][kc_s] && !bus.matriz[kf_s][kc_s] &&
                                 !marcada_r[kf_s][kc_s] && vecino_s;
                    if (revela_k_s) begin
                        revelada_s[kf_s][kc_s] = 1'b1;
                        reveladas_s            = reveladas_r + 7'd1;
                    end else begin
                        reveladas_s = reveladas_r;
                    end
                    if (k_r == 6'd63) begin
                        k_s      = 6'd0;
                        cambio_s = 1'b0;
                        if (cambio_r || revela_k_s) begin
                            estado_s = EXPANDE;
                        end else begin
                            estado_s = JUGANDO;
                        end
                    end else begin
                        k_s      = k_r + 6'd1;
                        cambio_s = cambio_r | revela_k_s;
                    end
                end
                ESPERA, PERDIDO, GANADO: begin
                    estado_s = estado_r;
                end
                default: begin
                    estado_s = ESPERA;
                end
            endcase
        end
    end

    // State and datapath registers; status flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_r    <= ESPERA;
            revelada_r  <= '0;
            marcada_r   <= '0;
            reveladas_r <= 7'd0;
            k_r         <= 6'd0;
            cambio_r    <= 1'b0;
            ocupado_r   <= 1'b0;
            perdio_r    <= 1'b0;
            gano_r      <= 1'b0;
        end else begin
            estado_r    <= estado_s;
            revelada_r  <= revelada_s;
            marcada_r   <= marcada_s;
            reveladas_r <= reveladas_s;
            k_r         <= k_s;
            cambio_r    <= cambio_s;
            ocupado_r   <= (estado_s == EXPANDE);
            perdio_r    <= (estado_s == PERDIDO);
            gano_r      <= (estado_s == GANADO);
        end
    end

    assign bus.revelada  = revelada_r;
    assign bus.marcada   = marcada_r;
    assign bus.reveladas = reveladas_r;
    assign bus.ocupado   = ocupado_r;
    assign bus.perdio    = perdio_r;
    assign bus.gano      = gano_r;

endmodule

// File: tb/tb_revelar_casillas.sv
// Directed self-checking bench for the minesweeper cell-reveal engine.
module tb_revelar_casillas;
    import buscaminas_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    revelar_casillas_if bus ();

    revelar_casillas dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:7][0:7][2:0] calc_bombas(input logic [7:0][7:0] m);
        logic [0:7][0:7][2:0] b;
        int rr, cc;
        b = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8 && m[rr][cc])
                            b[r][c] = b[r][c] + 3'd1;
                    end
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tablero(input logic [7:0][7:0] m, input logic [3:0] nm);
        bus.matriz            = m;
        bus.num_minas         = nm;
        bus.bombas_adyacentes = calc_bombas(m);
    endtask

    task automatic pulso_iniciar();
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
    endtask

    task automatic pulso_revelar(input int r, input int c);
        bus.sel_fila = coord_t'(r);
        bus.sel_col  = coord_t'(c);
        bus.revelar  = 1'b1;
        tick();
        bus.revelar  = 1'b0;
    endtask

    task automatic pulso_bandera(input int r, input int c);
        bus.sel_fila = coord_t'(r);
        bus.sel_col  = coord_t'(c);
        bus.bandera  = 1'b1;
        tick();
        bus.bandera  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.revelada !== 64'd0 || bus.marcada !== 64'd0 || bus.reveladas !== 7'd0) begin
            $display("FAIL reset_masks: revelada=%h marcada=%h reveladas=%0d, required 0/0/0",
                     bus.revelada, bus.marcada, bus.reveladas);
            errors++;
        end
        checks++;
        if (bus.ocupado !== 1'b0 || bus.perdio !== 1'b0 || bus.gano !== 1'b0) begin
            $display("FAIL reset_flags: ocupado=%b perdio=%b gano=%b, required 0/0/0",
                     bus.ocupado, bus.perdio, bus.gano);
            errors++;
        end
        pulso_revelar(3, 3);
        checks++;
        if (bus.revelada !== 64'd0 || bus.reveladas !== 7'd0 || bus.perdio !== 1'b0) begin
            $display("FAIL espera_ignora: revelada=%h reveladas=%0d perdio=%b, required 0/0/0",
                     bus.revelada, bus.reveladas, bus.perdio);
            errors++;
        end
        checks++;
        if (dut.estado_r !== ESPERA) begin
            $display("FAIL espera_estado: estado=%0d, required %0d", dut.estado_r, ESPERA);
            errors++;
        end
    endtask

    task automatic test_vacio();
        int ciclos;
        set_tablero(64'd0, 4'd0);
        pulso_iniciar();
        pulso_revelar(0, 0);
        ciclos = 0;
        while (bus.ocupado === 1'b1 && ciclos < 200) begin
            ciclos++;
            tick();
        end
        checks++;
        if (ciclos != 128) begin
            $display("FAIL vacio_ocupado: ocupado cycles=%0d, required 128", ciclos);
            errors++;
        end
        checks++;
        if (bus.revelada !== {64{1'b1}} || bus.reveladas !== 7'd64) begin
            $display("FAIL vacio_revelada: revelada=%h reveladas=%0d, required all ones/64",
                     bus.revelada, bus.reveladas);
            errors++;
        end
        checks++;
        if (bus.gano !== 1'b0) begin
            $display("FAIL vacio_gano_temprano: gano=%b, required 0", bus.gano);
            errors++;
        end
        tick();
        checks++;
        if (bus.gano !== 1'b1) begin
            $display("FAIL vacio_gano: gano=%b, required 1", bus.gano);
            errors++;
        end
    endtask

    task automatic test_perdida();
        logic [7:0][7:0] m;
        logic [7:0][7:0] esperado;
        m = '0;
        m[2][3] = 1'b1;
        m[5][5] = 1'b1;
        esperado = m;
        set_tablero(m, 4'd2);
        pulso_iniciar();
        pulso_revelar(2, 3);
        checks++;
        if (bus.perdio !== 1'b1 || bus.revelada !== esperado || bus.reveladas !== 7'd0) begin
            $display("FAIL perdida: perdio=%b revelada=%h reveladas=%0d, required 1/%h/0",
                     bus.perdio, bus.revelada, bus.reveladas, esperado);
            errors++;
        end
        pulso_revelar(0, 0);
        pulso_bandera(1, 1);
        checks++;
        if (bus.perdio !== 1'b1 || bus.revelada !== esperado || bus.marcada !== 64'd0) begin
            $display("FAIL perdida_terminal: perdio=%b revelada=%h marcada=%h, required 1/%h/0",
                     bus.perdio, bus.revelada, bus.marcada, esperado);
            errors++;
        end
    endtask

    task automatic test_bandera();
        logic [7:0][7:0] m;
        logic [7:0][7:0] solo00;
        m = '0;
        m[0][1] = 1'b1;
        solo00 = '0;
        solo00[0][0] = 1'b1;
        set_tablero(m, 4'd1);
        pulso_iniciar();
        pulso_bandera(0, 0);
        checks++;
        if (bus.marcada !== solo00) begin
            $display("FAIL bandera_pone: marcada=%h, required %h", bus.marcada, solo00);
            errors++;
        end
        pulso_revelar(0, 0);
        checks++;
        if (bus.revelada !== 64'd0 || bus.reveladas !== 7'd0) begin
            $display("FAIL bandera_bloquea: revelada=%h reveladas=%0d, required 0/0",
                     bus.revelada, bus.reveladas);
            errors++;
        end
        pulso_bandera(0, 0);
        checks++;
        if (bus.marcada !== 64'd0) begin
            $display("FAIL bandera_quita: marcada=%h, required 0", bus.marcada);
            errors++;
        end
        pulso_revelar(0, 0);
        checks++;
        if (bus.revelada !== solo00 || bus.reveladas !== 7'd1 || bus.ocupado !== 1'b0) begin
            $display("FAIL revelar_conteo1: revelada=%h reveladas=%0d ocupado=%b, required %h/1/0",
                     bus.revelada, bus.reveladas, bus.ocupado, solo00);
            errors++;
        end
    endtask

    task automatic test_simultaneo();
        logic [7:0][7:0] m;
        logic [7:0][7:0] solo77;
        m = '0;
        m[6][6] = 1'b1;
        m[6][7] = 1'b1;
        solo77 = '0;
        solo77[7][7] = 1'b1;
        set_tablero(m, 4'd2);
        pulso_iniciar();
        bus.sel_fila = 3'd7;
        bus.sel_col  = 3'd7;
        bus.revelar  = 1'b1;
        bus.bandera  = 1'b1;
        tick();
        bus.revelar  = 1'b0;
        bus.bandera  = 1'b0;
        checks++;
        if (bus.revelada !== solo77 || bus.marcada !== 64'd0 || bus.reveladas !== 7'd1 || bus.ocupado !== 1'b0) begin
            $display("FAIL simultaneo: revelada=%h marcada=%h reveladas=%0d ocupado=%b, required %h/0/1/0",
                     bus.revelada, bus.marcada, bus.reveladas, bus.ocupado, solo77);
            errors++;
        end
    endtask

    task automatic test_aborto();
        set_tablero(64'd0, 4'd0);
        pulso_iniciar();
        pulso_revelar(0, 0);
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (bus.ocupado !== 1'b1) begin
            $display("FAIL aborto_expande: ocupado=%b, required 1", bus.ocupado);
            errors++;
        end
        pulso_iniciar();
        checks++;
        if (bus.ocupado !== 1'b0 || bus.revelada !== 64'd0 || bus.reveladas !== 7'd0 || dut.estado_r !== JUGANDO) begin
            $display("FAIL aborto: ocupado=%b revelada=%h reveladas=%0d estado=%0d, required 0/0/0/%0d",
                     bus.ocupado, bus.revelada, bus.reveladas, dut.estado_r, JUGANDO);
            errors++;
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.iniciar  = 1'b0;
        bus.revelar  = 1'b0;
        bus.bandera  = 1'b0;
        bus.sel_fila = 3'd0;
        bus.sel_col  = 3'd0;
        set_tablero(64'd0, 4'd0);
        test_reset();
        test_vacio();
        test_perdida();
        test_bandera();
        test_simultaneo();
        test_aborto();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
